bin7seg_lut: RTL and testbench

BIN7SEG_LUT -- requirements
Module: bin7seg_lut

---
 rtl/bin7seg_lut.sv | 101 ++++++++++
 tb/tb_bin7seg_lut.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin7seg_lut.sv
// Registered 4-bit hex to seven-segment decoder with active-high segments.
// Define BIN7SEG_SOP_CHECK_EN to add an independent SOP decoder cross-check.
module bin7seg_lut (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic mismatch
);

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic [3:0] n;
  logic [6:0] lut_seg;
  logic [6:0] seg_q;

  assign n       = {D, C, B, A};
  assign lut_seg = SEG_LUT[n];

  // Output register; blank on reset, holds when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
    end else if (en) begin
      seg_q <= lut_seg;
    end
  end

  assign a = seg_q[6];
  assign b = seg_q[5];
  assign c = seg_q[4];
  assign d = seg_q[3];
  assign e = seg_q[2];
  assign f = seg_q[1];
  assign g = seg_q[0];

`ifdef BIN7SEG_SOP_CHECK_EN
  logic [6:0] sop_seg;
  logic       mis_q;

  // Each segment is the complement of a SOP over its dark digits.
  always_comb begin
    sop_seg[6] = ~((~D & ~C & ~B &  A) |
                   (~D &  C & ~B & ~A) |
                   ( D & ~C &  B &  A) |
                   ( D &  C & ~B &  A));
    sop_seg[5] = ~((~D &  C & ~B &  A) |
                   (~D &  C &  B & ~A) |
                   ( D & ~C &  B &  A) |
                   ( D &  C & ~B & ~A) |
                   ( D &  C &  B));
    sop_seg[4] = ~((~D & ~C &  B & ~A) |
                   ( D &  C & ~B & ~A) |
                   ( D &  C &  B));
    sop_seg[3] = ~((~D & ~C & ~B &  A) |
                   (~D &  C & ~B & ~A) |
                   (~D &  C &  B &  A) |
                   ( D & ~C &  B & ~A) |
                   ( D &  C &  B &  A));
    sop_seg[2] = ~((~D &  A) |
                   (~D &  C & ~B & ~A) |
                   ( D & ~C & ~B &  A));
    sop_seg[1] = ~((~D & ~C & ~B &  A) |
                   (~D & ~C &  B) |
                   (~D &  C &  B &  A) |
                   ( D &  C & ~B &  A));
    sop_seg[0] = ~((~D & ~C & ~B) |
                   (~D &  C &  B &  A) |
                   ( D &  C & ~B & ~A));
  end

  // Flag any disagreement between the two decoders, same timing as segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (en) begin
      mis_q <= |(lut_seg ^ sop_seg);
    end
  end

  assign mismatch = mis_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bin7seg_lut.sv
// Self-checking bench for bin7seg_lut.
// Reference model built from per-segment dark-digit sets.
module tb_bin7seg_lut;

  logic clk = 1'b0;
  logic rst_n, en, A, B, C, D;
  logic a, b, c, d, e, f, g, mismatch;
  int   tests = 0;
  int   fails = 0;

  bin7seg_lut dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .A(A), .B(B), .C(C), .D(D),
    .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model(int n);
    logic [6:0] s;
    s[6] = !(n inside {1, 4, 11, 13});
    s[5] = !(n inside {5, 6, 11, 12, 14, 15});
    s[4] = !(n inside {2, 12, 14, 15});
    s[3] = !(n inside {1, 4, 7, 10, 15});
    s[2] = !(n inside {1, 3, 4, 5, 7, 9});
    s[1] = !(n inside {1, 2, 3, 7, 13});
    s[0] = !(n inside {0, 1, 7, 12});
    return s;
  endfunction

  function automatic logic [6:0] segs();
    return {a, b, c, d, e, f, g};
  endfunction

  task automatic set_n(int n);
    {D, C, B, A} = 4'(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    set_n(8);
    #1;
    tests++;
    if (segs() !== 7'b0 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL reset: seg=%b mis=%b want 0000000/0",
               segs(), mismatch);
    end
    step();
    tests++;
    if (segs() !== 7'b0) begin
      fails++;
      $display("FAIL reset_clk: seg=%b want 0000000", segs());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [6:0] golden [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_n(i);
      step();
      tests++;
      if (segs() !== golden[i] || segs() !== model(i)) begin
        fails++;
        $display("FAIL sweep n=%0d: seg=%b want %b",
                 i, segs(), golden[i]);
      end
      tests++;
      if (mismatch !== 1'b0) begin
        fails++;
        $display("FAIL sweep_mis n=%0d: mis=%b want 0",
                 i, mismatch);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b1;
    set_n(2);
    step();
    en = 1'b0;
    set_n(7);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (segs() !== 7'b1101101) begin
        fails++;
        $display("FAIL hold cyc=%0d: seg=%b want 1101101",
                 i, segs());
      end
    end
  endtask

  task automatic test_wrap();
    en = 1'b1;
    set_n(15);
    step();
    tests++;
    if (segs() !== 7'b1000111) begin
      fails++;
      $display("FAIL wrap15: seg=%b want 1000111", segs());
    end
    set_n(0);
    step();
    tests++;
    if (segs() !== 7'b1111110) begin
      fails++;
      $display("FAIL wrap0: seg=%b want 1111110", segs());
    end
  endtask

  task automatic test_no_comb_path();
    en = 1'b1;
    set_n(3);
    step();
    set_n(12);
    #2;
    tests++;
    if (segs() !== model(3)) begin
      fails++;
      $display("FAIL comb_path: seg=%b want %b", segs(), model(3));
    end
  endtask

  task automatic test_random();
    logic [6:0] held;
    int n;
    held = segs();
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, 15));
      en = 1'($urandom_range(0, 1));
      set_n(n);
      if (en) held = model(n);
      step();
      tests++;
      if (segs() !== held || mismatch !== 1'b0) begin
        fails++;
        $display("FAIL random i=%0d n=%0d en=%b: seg=%b mis=%b want %b/0",
                 i, n, en, segs(), mismatch, held);
      end
    end
  endtask

  task automatic test_mid_reset();
    en = 1'b1;
    set_n(8);
    step();
    tests++;
    if (segs() !== 7'b1111111) begin
      fails++;
      $display("FAIL mid_pre: seg=%b want 1111111", segs());
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (segs() !== 7'b0 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: seg=%b mis=%b want 0000000/0",
               segs(), mismatch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_n(5);
    en = 1'b1;
    step();
    tests++;
    if (segs() !== 7'b1011011) begin
      fails++;
      $display("FAIL mid_release: seg=%b want 1011011", segs());
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_wrap();
    test_no_comb_path();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
